// File: rtl/chip_sched_if.sv
// Chip output path handshake: the scheduler drives data/valid/select, the sink returns ready.
interface chip_sched_if;
  logic [15:0] chip_d;
  logic        chip_vld;
  logic [6:0]  chip_sel;
  logic        chip_rdy;

  modport master (output chip_d, output chip_vld, output chip_sel, input chip_rdy);
  modport slave  (input chip_d, input chip_vld, input chip_sel, output chip_rdy);
endinterface

// File: rtl/chip_sched.sv
// Round-robin scheduler: qualifies eight channel samples against a threshold, holds one pending
// word per channel and forwards them one at a time to the chip output path with a ready timeout.
module chip_sched #(
  parameter int DROP_W = 16,
  parameter int SEQ_W  = 4
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               pluse_us,
  input  logic [127:0]       sm_data,
  input  logic               sm_vld,
  input  logic [7:0]         cfg_path_en,
  input  logic [15:0]        cfg_chip_th,
  input  logic [7:0]         cfg_timeout_us,
  chip_sched_if.master       chip,
  output logic [7:0]         stat_ovf,
  output logic [DROP_W-1:0]  stat_drop,
  output logic               stat_busy
);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t           state, state_nxt;
  logic [7:0]       pend;
  logic [7:0]       cap;
  logic [15:0]      smp_buf [8];
  logic [2:0]       ptr;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       us_cnt;
  logic [2:0]       sel_idx;
  logic [2:0]       probe;
  logic             found;
  logic             load;
  logic             xfer;
  logic             tmo;

  function automatic logic [7:0] sat_inc_us(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  always_comb begin
    cap = '0;
    for (int i = 0; i < 8; i++)
      cap[i] = sm_vld && cfg_path_en[i] && (sm_data[16*i +: 16] >= cfg_chip_th);
  end

  // First pending channel at or after ptr, wrapping modulo 8
  always_comb begin
    found   = 1'b0;
    sel_idx = ptr;
    probe   = ptr;
    for (int k = 0; k < 8; k++) begin
      probe = ptr + 3'(k);
      if (!found && pend[probe]) begin
        found   = 1'b1;
        sel_idx = probe;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transfer beats timeout when both are true in the same cycle
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (found) begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (chip.chip_rdy) begin
        xfer      = 1'b1;
        state_nxt = IDLE;
      end else if (cfg_timeout_us != 8'd0 && us_cnt == cfg_timeout_us) begin
        tmo       = 1'b1;
        state_nxt = DROP;
      end
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A capture on the channel being loaded re-arms pend without flagging an overwrite
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pend     <= '0;
      stat_ovf <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!cfg_path_en[i])                   pend[i] <= 1'b0;
        else if (cap[i])                       pend[i] <= 1'b1;
        else if (load && sel_idx == 3'(i))     pend[i] <= 1'b0;
        if (cap[i] && pend[i] && !(load && sel_idx == 3'(i)))
          stat_ovf[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 8; i++)
      if (cap[i]) smp_buf[i] <= sm_data[16*i +: 16];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      chip.chip_d   <= '0;
      chip.chip_vld <= 1'b0;
      chip.chip_sel <= '0;
      ptr           <= '0;
      seq           <= '0;
      us_cnt        <= '0;
      stat_drop     <= '0;
    end else begin
      if (load) begin
        chip.chip_d   <= smp_buf[sel_idx];
        chip.chip_sel <= {seq, sel_idx};
        chip.chip_vld <= 1'b1;
        us_cnt        <= '0;
      end else if (state == SEND) begin
        if (pluse_us) us_cnt <= sat_inc_us(us_cnt);
        if (xfer) begin
          chip.chip_vld <= 1'b0;
          seq           <= seq + SEQ_W'(1);
          ptr           <= chip.chip_sel[2:0] + 3'd1;
        end else if (tmo) begin
          chip.chip_vld <= 1'b0;
        end
      end else if (state == DROP) begin
        stat_drop <= sat_inc_drop(stat_drop);
        ptr       <= chip.chip_sel[2:0] + 3'd1;
      end
    end
  end

  assign stat_busy = (state == SEND);

endmodule

// File: tb/tb_chip_sched.sv
// Directed bench for chip_sched: reset, single word, round robin, timeout, overwrite,
// threshold/enable qualification and reset during SEND.
module tb_chip_sched;
  logic         clk_sys = 1'b0;
  logic         rst;
  logic         pluse_us;
  logic [127:0] sm_data;
  logic         sm_vld;
  logic [7:0]   cfg_path_en;
  logic [15:0]  cfg_chip_th;
  logic [7:0]   cfg_timeout_us;
  logic [7:0]   stat_ovf;
  logic [15:0]  stat_drop;
  logic         stat_busy;
  int           total = 0;
  int           bad = 0;

  chip_sched_if cif();

  chip_sched #(.DROP_W(16), .SEQ_W(4)) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .pluse_us       (pluse_us),
    .sm_data        (sm_data),
    .sm_vld         (sm_vld),
    .cfg_path_en    (cfg_path_en),
    .cfg_chip_th    (cfg_chip_th),
    .cfg_timeout_us (cfg_timeout_us),
    .chip           (cif),
    .stat_ovf       (stat_ovf),
    .stat_drop      (stat_drop),
    .stat_busy      (stat_busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pluse_us = 1'b0; sm_vld = 1'b0; sm_data = '0;
    cfg_path_en = 8'hFF; cfg_chip_th = 16'h0100; cfg_timeout_us = 8'd0;
    cif.chip_rdy = 1'b0;
    tick; tick;
    rst = 1'b0;
    total++;
    if (cif.chip_vld !== 1'b0 || cif.chip_d !== 16'h0 || cif.chip_sel !== 7'h0) begin
      bad++; $display("FAIL reset_chip: vld=%b d=%h sel=%h want 0/0/0", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    total++;
    if (stat_ovf !== 8'h0 || stat_drop !== 16'h0 || stat_busy !== 1'b0) begin
      bad++; $display("FAIL reset_stat: ovf=%h drop=%h busy=%b want 0/0/0", stat_ovf, stat_drop, stat_busy);
    end
  endtask

  task automatic test_single;
    do_reset;
    cif.chip_rdy = 1'b1;
    for (int i = 0; i < 8; i++) sm_data[16*i +: 16] = 16'h0050;
    sm_data[16*2 +: 16] = 16'h1234;
    sm_vld = 1'b1;
    tick;
    sm_vld = 1'b0;
    total++;
    if (cif.chip_vld !== 1'b0) begin
      bad++; $display("FAIL single_n1: vld got %b want 0", cif.chip_vld);
    end
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h1234 || cif.chip_sel !== 7'b0000_010 || stat_busy !== 1'b1) begin
      bad++; $display("FAIL single_n2: vld=%b d=%h sel=%b busy=%b want 1/1234/0000010/1",
                      cif.chip_vld, cif.chip_d, cif.chip_sel, stat_busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      total++;
      if (cif.chip_vld !== 1'b0) begin
        bad++; $display("FAIL single_after%0d: vld got %b want 0", c, cif.chip_vld);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [6:0] es;
    do_reset;
    cif.chip_rdy = 1'b1;
    for (int i = 0; i < 8; i++) sm_data[16*i +: 16] = 16'h0200 + 16'(i);
    for (int r = 0; r < 2; r++) begin
      sm_vld = 1'b1;
      tick;
      sm_vld = 1'b0;
      tick;
      for (int k = 0; k < 8; k++) begin
        es = {4'(r*8 + k), 3'(k)};
        total++;
        if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0200 + 16'(k) || cif.chip_sel !== es) begin
          bad++; $display("FAIL rr_word r%0d k%0d: vld=%b d=%h sel=%b want 1/%h/%b",
                          r, k, cif.chip_vld, cif.chip_d, cif.chip_sel, 16'h0200 + 16'(k), es);
        end
        tick;
        total++;
        if (cif.chip_vld !== 1'b0) begin
          bad++; $display("FAIL rr_gap r%0d k%0d: vld got %b want 0", r, k, cif.chip_vld);
        end
        tick;
      end
    end
    sm_vld = 1'b1;
    tick;
    sm_vld = 1'b0;
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_sel !== 7'b0000_000 || cif.chip_d !== 16'h0200) begin
      bad++; $display("FAIL rr_wrap: vld=%b d=%h sel=%b want 1/0200/0000000", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
  endtask

  task automatic test_timeout;
    do_reset;
    cif.chip_rdy = 1'b0;
    cfg_timeout_us = 8'd3;
    sm_data = '0;
    sm_data[16*0 +: 16] = 16'h0300;
    sm_data[16*1 +: 16] = 16'h0400;
    sm_vld = 1'b1;
    tick;
    sm_vld = 1'b0;
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0300 || cif.chip_sel !== 7'h0) begin
      bad++; $display("FAIL to_load: vld=%b d=%h sel=%b want 1/0300/0000000", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    for (int c = 1; c <= 25; c++) begin
      pluse_us = (c % 10 == 5);
      tick;
      total++;
      if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0300 || cif.chip_sel !== 7'h0) begin
        bad++; $display("FAIL to_hold c%0d: vld=%b d=%h sel=%b want 1/0300/0000000",
                        c, cif.chip_vld, cif.chip_d, cif.chip_sel);
      end
    end
    pluse_us = 1'b0;
    tick;
    total++;
    if (cif.chip_vld !== 1'b0 || stat_drop !== 16'd0) begin
      bad++; $display("FAIL to_drop_state: vld=%b drop=%0d want 0/0", cif.chip_vld, stat_drop);
    end
    tick;
    total++;
    if (cif.chip_vld !== 1'b0 || stat_drop !== 16'd1) begin
      bad++; $display("FAIL to_drop_count: vld=%b drop=%0d want 0/1", cif.chip_vld, stat_drop);
    end
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0400 || cif.chip_sel !== 7'b0000_001) begin
      bad++; $display("FAIL to_next: vld=%b d=%h sel=%b want 1/0400/0000001", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    cif.chip_rdy = 1'b1;
    tick;
    total++;
    if (cif.chip_vld !== 1'b0 || stat_drop !== 16'd1) begin
      bad++; $display("FAIL to_accept: vld=%b drop=%0d want 0/1", cif.chip_vld, stat_drop);
    end
    cfg_timeout_us = 8'd0;
  endtask

  task automatic test_overwrite;
    do_reset;
    cif.chip_rdy = 1'b0;
    cfg_timeout_us = 8'd0;
    sm_data = '0;
    sm_data[16*0 +: 16] = 16'h0200;
    sm_vld = 1'b1;
    tick;
    sm_vld = 1'b0;
    tick;
    sm_data = '0;
    sm_data[16*5 +: 16] = 16'h0200;
    sm_vld = 1'b1;
    tick;
    total++;
    if (stat_ovf !== 8'h00) begin
      bad++; $display("FAIL ovf_first: ovf got %h want 00", stat_ovf);
    end
    sm_data[16*5 +: 16] = 16'h0300;
    tick;
    sm_vld = 1'b0;
    total++;
    if (stat_ovf !== 8'h20 || cif.chip_vld !== 1'b1 || cif.chip_sel !== 7'h0) begin
      bad++; $display("FAIL ovf_second: ovf=%h vld=%b sel=%b want 20/1/0000000", stat_ovf, cif.chip_vld, cif.chip_sel);
    end
    cif.chip_rdy = 1'b1;
    tick;
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0300 || cif.chip_sel !== 7'b0001_101) begin
      bad++; $display("FAIL ovf_send: vld=%b d=%h sel=%b want 1/0300/0001101", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      total++;
      if (cif.chip_vld !== 1'b0 || stat_ovf !== 8'h20) begin
        bad++; $display("FAIL ovf_once c%0d: vld=%b ovf=%h want 0/20", c, cif.chip_vld, stat_ovf);
      end
    end
  endtask

  task automatic test_threshold_enable;
    do_reset;
    cif.chip_rdy = 1'b1;
    cfg_chip_th = 16'h0100;
    cfg_path_en = 8'hF7;
    sm_data = '0;
    sm_data[16*1 +: 16] = 16'h0100;
    sm_data[16*2 +: 16] = 16'h00FF;
    sm_data[16*3 +: 16] = 16'hFFFF;
    sm_vld = 1'b1;
    tick;
    sm_vld = 1'b0;
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0100 || cif.chip_sel !== 7'b0000_001) begin
      bad++; $display("FAIL th_send: vld=%b d=%h sel=%b want 1/0100/0000001", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    for (int c = 0; c < 6; c++) begin
      tick;
      total++;
      if (cif.chip_vld !== 1'b0) begin
        bad++; $display("FAIL th_only c%0d: vld got %b d=%h want 0", c, cif.chip_vld, cif.chip_d);
      end
    end
    cfg_path_en = 8'hFF;
  endtask

  task automatic test_reset_mid_send;
    do_reset;
    cif.chip_rdy = 1'b0;
    cfg_timeout_us = 8'd0;
    sm_data = '0;
    sm_data[16*4 +: 16] = 16'h0500;
    sm_data[16*6 +: 16] = 16'h0600;
    sm_vld = 1'b1;
    tick;
    tick;
    sm_vld = 1'b0;
    cfg_timeout_us = 8'd1;
    pluse_us = 1'b1;
    tick;
    pluse_us = 1'b0;
    tick;
    tick;
    cfg_timeout_us = 8'd0;
    total++;
    if (stat_ovf !== 8'h40 || stat_drop !== 16'd1 || cif.chip_vld !== 1'b0) begin
      bad++; $display("FAIL rms_pre: ovf=%h drop=%0d vld=%b want 40/1/0", stat_ovf, stat_drop, cif.chip_vld);
    end
    tick;
    total++;
    if (cif.chip_vld !== 1'b1 || cif.chip_d !== 16'h0600 || cif.chip_sel !== 7'b0000_110) begin
      bad++; $display("FAIL rms_send: vld=%b d=%h sel=%b want 1/0600/0000110", cif.chip_vld, cif.chip_d, cif.chip_sel);
    end
    do_reset;
    total++;
    if (cif.chip_vld !== 1'b0 || cif.chip_d !== 16'h0 || cif.chip_sel !== 7'h0 ||
        stat_ovf !== 8'h0 || stat_drop !== 16'h0 || stat_busy !== 1'b0) begin
      bad++; $display("FAIL rms_clear: vld=%b d=%h sel=%h ovf=%h drop=%h busy=%b want all 0",
                      cif.chip_vld, cif.chip_d, cif.chip_sel, stat_ovf, stat_drop, stat_busy);
    end
    cif.chip_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      total++;
      if (cif.chip_vld !== 1'b0 || stat_busy !== 1'b0) begin
        bad++; $display("FAIL rms_quiet c%0d: vld=%b busy=%b want 0/0", c, cif.chip_vld, stat_busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_overwrite;
    test_threshold_enable;
    test_reset_mid_send;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
